alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 156 +++++++++++++++
 tb/tb_alu_mc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides. Logic and add/sub
// finish in one cycle; shifts step one bit per cycle; MUL is a WIDTH-step shift-add.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] td,
  output logic [2:0]       psw,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRA, K_MUL} kind_t;
  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_OR = 4'h1, OP_XOR = 4'h2, OP_NOT = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_SLL = 4'h6, OP_SRA = 4'h7,
    OP_MUL = 4'h8
  } op_t;

  state_t           state;
  kind_t            kind;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] res;
  logic             res_v;
  logic             res_n;
  logic             res_ill;
  logic             is_shift;
  logic             is_mul;
  logic [31:0]      shamt_ext;
  logic [CW-1:0]    steps;

  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] fin;

  // Single-cycle results; shifts pass src1 through for the shamt == 0 case.
  always_comb begin
    res       = '0;
    res_v     = 1'b0;
    res_n     = 1'b0;
    res_ill   = 1'b0;
    is_shift  = 1'b0;
    is_mul    = 1'b0;
    shamt_ext = 32'(shamt);
    steps     = (shamt_ext >= 32'(WIDTH)) ? CW'(WIDTH) : CW'(shamt_ext);
    case (opcode)
      OP_AND: res = alu_src1 & alu_src2;
      OP_OR:  res = alu_src1 | alu_src2;
      OP_XOR: res = alu_src1 ^ alu_src2;
      OP_NOT: res = ~alu_src1;
      OP_ADD: begin
        res   = alu_src1 + alu_src2;
        res_v = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) && (res[WIDTH-1] != alu_src1[WIDTH-1]);
        res_n = res[WIDTH-1];
      end
      OP_SUB: begin
        res   = alu_src1 - alu_src2;
        res_v = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) && (res[WIDTH-1] != alu_src1[WIDTH-1]);
        res_n = res[WIDTH-1];
      end
      OP_SLL, OP_SRA: begin
        res      = alu_src1;
        is_shift = 1'b1;
      end
      OP_MUL:  is_mul  = 1'b1;
      default: res_ill = 1'b1;
    endcase
  end

  // One iteration; the multiplicand shifts left exactly like SLL does.
  always_comb begin
    a_step   = (kind == K_SRA) ? {opa[WIDTH-1], opa[WIDTH-1:1]} : {opa[WIDTH-2:0], 1'b0};
    acc_step = opb[0] ? acc + opa : acc;
    fin      = (kind == K_MUL) ? acc_step : a_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kind      <= K_SLL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      td        <= '0;
      psw       <= '0;
      illegal   <= 1'b0;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            opa      <= alu_src1;
            opb      <= alu_src2;
            acc      <= '0;
            if (is_mul) begin
              kind  <= K_MUL;
              cnt   <= CW'(WIDTH);
              state <= BUSY;
            end else if (is_shift && steps != '0) begin
              kind  <= (opcode == OP_SRA) ? K_SRA : K_SLL;
              cnt   <= steps;
              state <= BUSY;
            end else begin
              td        <= res;
              psw       <= {(res == '0) && !res_ill, res_v, res_n};
              illegal   <= res_ill;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          opa <= a_step;
          opb <= opb >> 1;
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            td        <= fin;
            psw       <= {fin == '0, 1'b0, (kind == K_MUL) && fin[WIDTH-1]};
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: vector table, random ops against a reference model, and
// hand sequences for back-pressure and reset-abort behaviour.
module tb_alu_mc;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic [SW-1:0] shamt = '0;
  logic          in_ready;
  logic          out_valid;
  logic          illegal;
  logic [W-1:0]  td;
  logic [2:0]    psw;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .SHW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_src1(src1), .alu_src2(src2), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .td(td), .psw(psw),
    .illegal(illegal)
  );

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sh;
    logic [W-1:0]  td;
    logic [2:0]    psw;
    logic          ill;
    int            lat;
    string         name;
  } vec_t;

  typedef struct {
    logic [W-1:0] td;
    logic [2:0]   psw;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one request, push its expectation, then pop and compare on out_valid.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] sh, input logic [W-1:0] etd, input logic [2:0] epsw,
                        input logic eill, input int elat, input string name);
    int   guard = 0;
    int   lat;
    bit   seen_ready = 1'b0;
    exp_t e;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check({name, "_ready_timeout"}, in_ready, 1);
      return;
    end
    opcode = op; src1 = a; src2 = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 4'($urandom); src1 = W'($urandom); src2 = W'($urandom); shamt = SW'($urandom);
    e.td = etd; e.psw = epsw; e.ill = eill;
    sb.push_back(e);
    lat = 1;
    while (!out_valid && lat < 200) begin
      seen_ready |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_out_valid"}, out_valid, 1);
    e = sb.pop_front();
    if (!out_valid) return;
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_in_ready_low"}, seen_ready | in_ready, 0);
    check({name, "_td"}, td, e.td);
    check({name, "_psw"}, psw, e.psw);
    check({name, "_illegal"}, illegal, e.ill);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [SW-1:0] sh);
    exp_t               r;
    logic signed [W-1:0] sa;
    logic [31:0]        p;
    int                 s;
    logic               v = 1'b0;
    logic               n = 1'b0;
    sa = a;
    r.ill = 1'b0;
    case (op)
      4'h0: r.td = a & b;
      4'h1: r.td = a | b;
      4'h2: r.td = a ^ b;
      4'h3: r.td = ~a;
      4'h4: begin
        r.td = a + b; s = int'($signed(a)) + int'($signed(b));
        v = (s > 32767) || (s < -32768); n = r.td[W-1];
      end
      4'h5: begin
        r.td = a - b; s = int'($signed(a)) - int'($signed(b));
        v = (s > 32767) || (s < -32768); n = r.td[W-1];
      end
      4'h6: r.td = a << sh;
      4'h7: r.td = sa >>> sh;
      4'h8: begin p = a * b; r.td = p[W-1:0]; n = r.td[W-1]; end
      default: begin r.td = '0; r.ill = 1'b1; end
    endcase
    r.psw = {(r.td == '0) && !r.ill, v, n};
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [SW-1:0] sh);
    if (op == 4'h8) return W + 1;
    if ((op == 4'h6 || op == 4'h7) && sh != 0) return int'(sh) + 1;
    return 1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    logic [SW-1:0] rsh;

    vecs[0]  = '{4'h0, 16'hF0F0, 16'h3C3C, 4'd0,  16'h3030, 3'b000, 1'b0, 1,  "and"};
    vecs[1]  = '{4'h1, 16'hF0F0, 16'h0F00, 4'd0,  16'hFFF0, 3'b000, 1'b0, 1,  "or"};
    vecs[2]  = '{4'h2, 16'hAAAA, 16'hAAAA, 4'd0,  16'h0000, 3'b100, 1'b0, 1,  "xor_zero"};
    vecs[3]  = '{4'h3, 16'h00FF, 16'h1234, 4'd0,  16'hFF00, 3'b000, 1'b0, 1,  "not"};
    vecs[4]  = '{4'h4, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 3'b011, 1'b0, 1,  "add_ovf"};
    vecs[5]  = '{4'h4, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 3'b100, 1'b0, 1,  "add_wrap"};
    vecs[6]  = '{4'h5, 16'h0005, 16'h0005, 4'd0,  16'h0000, 3'b100, 1'b0, 1,  "sub_zero"};
    vecs[7]  = '{4'h5, 16'h8000, 16'h0001, 4'd0,  16'h7FFF, 3'b010, 1'b0, 1,  "sub_ovf"};
    vecs[8]  = '{4'h7, 16'hF000, 16'h0000, 4'd4,  16'hFF00, 3'b000, 1'b0, 5,  "sra4"};
    vecs[9]  = '{4'h6, 16'h0001, 16'h0000, 4'd15, 16'h8000, 3'b000, 1'b0, 16, "sll15"};
    vecs[10] = '{4'h6, 16'h1234, 16'h0000, 4'd0,  16'h1234, 3'b000, 1'b0, 1,  "sll0"};
    vecs[11] = '{4'h8, 16'h00FF, 16'h0101, 4'd0,  16'hFFFF, 3'b001, 1'b0, 17, "mul"};
    vecs[12] = '{4'hF, 16'h1234, 16'h5678, 4'd3,  16'h0000, 3'b000, 1'b1, 1,  "illegal_f"};
    vecs[13] = '{4'h4, 16'h0001, 16'h0002, 4'd0,  16'h0003, 3'b000, 1'b0, 1,  "add_after_ill"};
    vecs[14] = '{4'h8, 16'h1234, 16'h0000, 4'd0,  16'h0000, 3'b100, 1'b0, 17, "mul_zero"};
    vecs[15] = '{4'h4, 16'h8000, 16'h8000, 4'd0,  16'h0000, 3'b110, 1'b0, 1,  "add_neg_ovf"};
    vecs[16] = '{4'h9, 16'hFFFF, 16'hFFFF, 4'd7,  16'h0000, 3'b000, 1'b1, 1,  "illegal_9"};
    vecs[17] = '{4'h7, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 3'b000, 1'b0, 16, "sra15"};
    vecs[18] = '{4'h5, 16'h0000, 16'h0001, 4'd0,  16'hFFFF, 3'b001, 1'b0, 1,  "sub_neg"};

    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_td", td, 0);
    check("rst_psw", psw, 0);
    check("rst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].td, vecs[i].psw,
             vecs[i].ill, vecs[i].lat, vecs[i].name);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = W'($urandom); rb = W'($urandom); rsh = SW'($urandom);
      e = model(rop, ra, rb, rsh);
      run_op(rop, ra, rb, rsh, e.td, e.psw, e.ill, model_lat(rop, rsh), $sformatf("rand%0d", i));
    end

    // Back-pressure: result must hold and a pending request must wait for IDLE.
    out_ready = 1'b0;
    run_op(4'h8, 16'h00FF, 16'h0101, 4'd0, 16'hFFFF, 3'b001, 1'b0, 17, "mul_hold");
    opcode = 4'h4; src1 = 16'h0002; src2 = 16'h0003; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_td", td, 16'hFFFF);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    e.td = 16'h0005; e.psw = 3'b000; e.ill = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    check("post_hold_out_valid", out_valid, 1);
    check("post_hold_td", td, e.td);
    check("post_hold_psw", psw, e.psw);
    @(posedge clk); #1;

    // Reset in the middle of a multiply aborts it with no result.
    opcode = 4'h8; src1 = 16'h0003; src2 = 16'h0007; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_td", td, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_psw", psw, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h4, 16'h1111, 16'h2222, 4'd0, 16'h3333, 3'b000, 1'b0, 1, "add_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
